// File: rtl/ddr3_iod_rx_delay_trainer.sv
// RX delay-line trainer: sweeps one IOD input delay tap by tap, tracks the widest
// window where the deserialized data matches the training pattern, then parks at its centre.
module ddr3_iod_rx_delay_trainer #(
    parameter int         MAX_TAPS      = 128,
    parameter int         SETTLE_CYCLES = 8,
    parameter int         SAMPLE_CYCLES = 16,
    parameter int         MIN_EYE       = 4,
    parameter logic [3:0] EXP_PATTERN   = 4'b1010
) (
    input  logic       FAB_CLK,
    input  logic       ARST_N,
    input  logic       START,
    input  logic [3:0] RX_DATA_0,
    input  logic       DELAY_LINE_OUT_OF_RANGE_0,
    output logic       DELAY_LINE_MOVE_0,
    output logic       DELAY_LINE_DIRECTION_0,
    output logic       DELAY_LINE_LOAD_0,
    output logic       BUSY,
    output logic       DONE,
    output logic       FAIL,
    output logic [7:0] CUR_TAP,
    output logic [7:0] TAP_CENTER,
    output logic [7:0] EYE_WIDTH,
    output logic [3:0] DBG_STATE
);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_SAMPLE, S_EVAL,
        S_STEP, S_CENTER, S_CSETTLE, S_DONE, S_FAIL
    } state_e;

    localparam int              CNT_W       = 16;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [7:0]      LAST_TAP    = 8'(MAX_TAPS - 1);
    localparam logic [7:0]      MIN_W       = 8'(MIN_EYE);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             match_q, phase_q, dir_q, done_q, fail_q;
    logic [7:0]       cur_tap_q, center_q, eye_q;
    logic             win_open_q;
    logic [7:0]       win_start_q, win_width_q, best_start_q, best_width_q;

    logic       start_ok, settle_done, sample_done, tap_pass, scan_end;
    logic       closing, take, eye_ok, at_center;
    logic [7:0] run_width, run_start, close_width, close_start, fin_width, fin_start;

    assign start_ok    = START && (state_q == S_IDLE || state_q == S_DONE || state_q == S_FAIL);
    assign settle_done = (cnt_q == SETTLE_LAST);
    assign sample_done = (cnt_q == SAMPLE_LAST);
    assign tap_pass    = match_q && !DELAY_LINE_OUT_OF_RANGE_0;
    assign scan_end    = (cur_tap_q == LAST_TAP) || DELAY_LINE_OUT_OF_RANGE_0;
    assign at_center   = (cur_tap_q == center_q);

    // The window that would exist after this tap, and the one that closes on this tap.
    assign run_width   = !win_open_q ? 8'd1 : (win_width_q == 8'hFF ? 8'hFF : win_width_q + 8'd1);
    assign run_start   = win_open_q ? win_start_q : cur_tap_q;
    assign close_width = tap_pass ? run_width : win_width_q;
    assign close_start = tap_pass ? run_start : win_start_q;
    assign closing     = tap_pass ? scan_end : win_open_q;
    assign take        = closing && (close_width > best_width_q);
    assign fin_width   = take ? close_width : best_width_q;
    assign fin_start   = take ? close_start : best_start_q;
    assign eye_ok      = (fin_width >= MIN_W);

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_FAIL: if (start_ok) state_d = S_LOAD;
            S_LOAD:    state_d = S_SETTLE;
            S_SETTLE:  if (settle_done) state_d = S_SAMPLE;
            S_SAMPLE:  if (sample_done) state_d = S_EVAL;
            S_EVAL:    state_d = !scan_end ? S_STEP : (eye_ok ? S_CENTER : S_FAIL);
            S_STEP:    state_d = S_SETTLE;
            S_CENTER:  if (!phase_q && at_center) state_d = S_CSETTLE;
            S_CSETTLE: if (settle_done) state_d = S_DONE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        DELAY_LINE_MOVE_0 = 1'b0;
        DELAY_LINE_LOAD_0 = 1'b0;
        BUSY              = 1'b1;
        case (state_q)
            S_IDLE, S_DONE, S_FAIL: BUSY = 1'b0;
            S_LOAD:   DELAY_LINE_LOAD_0 = 1'b1;
            S_STEP:   DELAY_LINE_MOVE_0 = 1'b1;
            S_CENTER: DELAY_LINE_MOVE_0 = phase_q;
            default:  BUSY = 1'b1;
        endcase
    end

    assign DELAY_LINE_DIRECTION_0 = dir_q;
    assign DONE       = done_q;
    assign FAIL       = fail_q;
    assign CUR_TAP    = cur_tap_q;
    assign TAP_CENTER = center_q;
    assign EYE_WIDTH  = eye_q;
    assign DBG_STATE  = state_q;

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            cnt_q <= '0;        match_q <= 1'b0;     phase_q <= 1'b0;
            dir_q <= 1'b0;      done_q <= 1'b0;      fail_q <= 1'b0;
            cur_tap_q <= '0;    center_q <= '0;      eye_q <= '0;
            win_open_q <= 1'b0; win_start_q <= '0;   win_width_q <= '0;
            best_start_q <= '0; best_width_q <= '0;
        end else begin
            if (state_d != state_q)
                cnt_q <= '0;
            else if (state_q == S_SETTLE || state_q == S_SAMPLE || state_q == S_CSETTLE)
                cnt_q <= cnt_q + CNT_W'(1);

            case (state_q)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (start_ok) begin
                        done_q <= 1'b0;     fail_q <= 1'b0;     eye_q <= '0;
                        center_q <= '0;     cur_tap_q <= '0;    dir_q <= 1'b1;
                        phase_q <= 1'b0;    win_open_q <= 1'b0; win_start_q <= '0;
                        win_width_q <= '0;  best_start_q <= '0; best_width_q <= '0;
                    end
                end
                S_SETTLE: match_q <= 1'b1;
                S_SAMPLE: if (RX_DATA_0 != EXP_PATTERN) match_q <= 1'b0;
                S_EVAL: begin
                    win_open_q <= tap_pass && !scan_end;
                    if (tap_pass) begin
                        win_width_q <= run_width;
                        win_start_q <= run_start;
                    end
                    if (take) begin
                        best_width_q <= close_width;
                        best_start_q <= close_start;
                    end
                    if (scan_end) begin
                        eye_q <= fin_width;
                        if (eye_ok) begin
                            center_q <= fin_start + {1'b0, fin_width[7:1]};
                            dir_q    <= 1'b0;
                        end else begin
                            fail_q <= 1'b1;
                        end
                    end
                end
                S_STEP: if (cur_tap_q != 8'hFF) cur_tap_q <= cur_tap_q + 8'd1;
                // Pulse/gap alternation; the first CENTER cycle is a gap so DIRECTION is stable.
                S_CENTER: begin
                    if (phase_q) begin
                        if (cur_tap_q != 8'd0) cur_tap_q <= cur_tap_q - 8'd1;
                        phase_q <= 1'b0;
                    end else if (!at_center) begin
                        phase_q <= 1'b1;
                    end
                end
                S_CSETTLE: if (settle_done) done_q <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule
